// File: rtl/pattern_matcher.sv
// pattern_matcher: sliding-window symbol matcher with per-bit mask, n-of-run detection and saturating match count.
module pattern_matcher #(
    parameter int DATA_W = 8,
    parameter int PAT_LEN = 4,
    parameter logic [DATA_W*PAT_LEN-1:0] PATTERN = 32'hAABBCCDD,
    parameter int CNT_W = 8,
    parameter int OVERLAP = 1,
    parameter int STICKY = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [DATA_W*PAT_LEN-1:0] mask,
    input  logic [CNT_W-1:0]          n,
    output logic                      match_pulse,
    output logic                      pattern_detected,
    output logic [CNT_W-1:0]          match_count
);
    localparam int WIN_W = DATA_W*(PAT_LEN-1);
    localparam int FILL_W = $clog2(PAT_LEN);
    localparam int GAP_W = $clog2(PAT_LEN+1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN-1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(PAT_LEN);
    logic [WIN_W-1:0] window_q, window_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [GAP_W-1:0] gap_q, gap_d, gap_inc;
    logic [CNT_W-1:0] run_q, run_d, match_count_q, match_count_d, thr;
    logic [CNT_W:0] run_next;
    logic match_pulse_q, match_pulse_d, detected_q, detected_d;
    logic [DATA_W*PAT_LEN-1:0] cand;
    logic hit, det_hit;
    always_comb begin
        cand = {window_q, in_data};
        hit = in_valid && (fill_q == FILL_MAX) && (((cand ^ PATTERN) & ~mask) == '0);
        thr = (n == '0) ? CNT_W'(1) : n;
        run_next = (CNT_W+1)'(run_q) + (CNT_W+1)'(1);
        // >= rather than == so a threshold lowered mid-run still fires on the next match
        det_hit = hit && (run_next >= (CNT_W+1)'(thr));
        gap_inc = (gap_q == GAP_MAX) ? gap_q : gap_q + GAP_W'(1);
        window_d = window_q;
        fill_d = fill_q;
        gap_d = gap_q;
        run_d = run_q;
        match_count_d = match_count_q;
        match_pulse_d = hit;
        detected_d = (STICKY != 0) ? (detected_q | det_hit) : det_hit;
        if (in_valid) begin
            window_d = cand[WIN_W-1:0];
            if (hit) begin
                fill_d = (OVERLAP != 0) ? fill_q : '0;
                gap_d = '0;
                run_d = det_hit ? '0 : run_next[CNT_W-1:0];
                match_count_d = (match_count_q == '1) ? match_count_q : match_count_q + CNT_W'(1);
            end else begin
                fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
                gap_d = gap_inc;
                run_d = (gap_inc == GAP_MAX) ? '0 : run_q;
            end
        end
        if (clear) begin
            window_d = '0;
            fill_d = '0;
            gap_d = '0;
            run_d = '0;
            match_count_d = '0;
            match_pulse_d = 1'b0;
            detected_d = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_q <= '0;
            fill_q <= '0;
            gap_q <= '0;
            run_q <= '0;
            match_count_q <= '0;
            match_pulse_q <= 1'b0;
            detected_q <= 1'b0;
        end else begin
            window_q <= window_d;
            fill_q <= fill_d;
            gap_q <= gap_d;
            run_q <= run_d;
            match_count_q <= match_count_d;
            match_pulse_q <= match_pulse_d;
            detected_q <= detected_d;
        end
    end
    assign match_pulse = match_pulse_q;
    assign pattern_detected = detected_q;
    assign match_count = match_count_q;
endmodule
